// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU command issuer: opcode encodings,
// number of legal opcodes and the response flag bundle.
package alu_issue_pkg;

    localparam logic [3:0] OP_SLT  = 4'd0;
    localparam logic [3:0] OP_NOR  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_SEQ  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_MAX  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_SNE  = 4'd11;

    localparam int NUM_OPS = 12;

    // Field widths of the default configuration.
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_SHIFT_W = 5;
    localparam int DEF_OPC_W   = 4;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_CNT_W   = 16;

    // Status flags carried alongside every response.
    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic err;
    } rsp_flags_t;

endpackage

// File: rtl/alu_issue_fixup.sv
// Combinational result/flag fixup: compare opcodes are evaluated locally,
// illegal opcodes are forced to zero with err set, and the SUB borrow is
// reconstructed because the ALU itself does not report it.
module alu_issue_fixup
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPC_W = DEF_OPC_W
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result,
    output rsp_flags_t       flags
);

    // Select final result, then derive flags from it.
    always_comb begin
        result      = alu_result;
        flags.err   = 1'b0;
        flags.carry = 1'b0;
        if (opcode >= OPC_W'(NUM_OPS)) begin
            result    = '0;
            flags.err = 1'b1;
        end else begin
            case (opcode)
                OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
                OP_SEQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
                OP_SNE:  result = {{(WIDTH-1){1'b0}}, (a != b)};
                default: result = alu_result;
            endcase
            flags.carry = (opcode == OP_SUB) && (a < b);
        end
        flags.zero = (result == '0);
        flags.sign = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Two-stage command issuer for the combinational ALU.
// Stage 1 holds the accepted command and drives the ALU; stage 2 holds the
// fixed-up response. Optional feature macro: ALU_ISSUE_FWD_EN (operand A
// forwarding from the previous result).
// Handshake: a transfer happens on a cycle where valid & ready are both 1;
// a producer keeps valid and payload stable until that cycle, and ready
// never depends on the same side's valid.
module alu_cmd_issuer
    import alu_issue_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHIFT_W = DEF_SHIFT_W,
    parameter int OPC_W   = DEF_OPC_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OPC_W-1:0]   cmd_opcode,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [SHIFT_W-1:0] cmd_shift,
    input  logic [TAG_W-1:0]   cmd_tag,
    input  logic               cmd_fwd,
    output logic [OPC_W-1:0]   alu_opcode,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [SHIFT_W-1:0] alu_shift,
    input  logic [WIDTH-1:0]   alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic               rsp_sign,
    output logic               rsp_err,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [CNT_W-1:0]   op_count
);

    logic               s1_valid;
    logic [OPC_W-1:0]   s1_opcode;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [SHIFT_W-1:0] s1_shift;
    logic [TAG_W-1:0]   s1_tag;
    logic [WIDTH-1:0]   eff_a;
    logic [WIDTH-1:0]   fix_result;
    rsp_flags_t         fix_flags;
    rsp_flags_t         rsp_flags;
    logic               advance1;
    logic               advance2;
    logic               accept;

    assign advance2  = !rsp_valid || rsp_ready;
    assign advance1  = s1_valid && advance2;
    assign cmd_ready = !s1_valid || advance2;
    assign accept    = cmd_valid && cmd_ready;

`ifdef ALU_ISSUE_FWD_EN
    logic             s1_fwd;
    logic [WIDTH-1:0] last_result;

    assign eff_a = s1_fwd ? last_result : s1_a;

    // Forward flag follows the command; last_result tracks every issued result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_fwd      <= 1'b0;
            last_result <= '0;
        end else begin
            if (accept)   s1_fwd      <= cmd_fwd;
            if (advance1) last_result <= fix_result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = cmd_fwd;
    assign eff_a      = s1_a;
`endif

    assign alu_opcode = s1_opcode;
    assign alu_input1 = eff_a;
    assign alu_input2 = s1_b;
    assign alu_shift  = s1_shift;

    alu_issue_fixup #(
        .WIDTH (WIDTH),
        .OPC_W (OPC_W)
    ) u_fixup (
        .opcode     (s1_opcode),
        .a          (eff_a),
        .b          (s1_b),
        .alu_result (alu_result),
        .result     (fix_result),
        .flags      (fix_flags)
    );

    // Stage 1: payload loads only on accept so the ALU inputs stay put when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_opcode <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_shift  <= '0;
            s1_tag    <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_opcode <= cmd_opcode;
            s1_a      <= cmd_a;
            s1_b      <= cmd_b;
            s1_shift  <= cmd_shift;
            s1_tag    <= cmd_tag;
        end else if (advance1) begin
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2: capture the fixed-up response whenever stage 1 advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_tag    <= '0;
        end else if (advance2) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_result <= fix_result;
                rsp_flags  <= fix_flags;
                rsp_tag    <= s1_tag;
            end
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign rsp_carry = rsp_flags.carry;
    assign rsp_zero  = rsp_flags.zero;
    assign rsp_sign  = rsp_flags.sign;
    assign rsp_err   = rsp_flags.err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural model of the external ALU.
module tb_alu_cmd_issuer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [4:0] cmd_shift;
    logic [3:0] cmd_tag;
    logic       cmd_fwd;
    logic [3:0] alu_opcode;
    logic [7:0] alu_input1;
    logic [7:0] alu_input2;
    logic [4:0] alu_shift;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_sign;
    logic       rsp_err;
    logic [3:0] rsp_tag;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];

    alu_cmd_issuer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_shift  (cmd_shift),
        .cmd_tag    (cmd_tag),
        .cmd_fwd    (cmd_fwd),
        .alu_opcode (alu_opcode),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_shift  (alu_shift),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_sign   (rsp_sign),
        .rsp_err    (rsp_err),
        .rsp_tag    (rsp_tag),
        .op_count   (op_count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model; compare/illegal opcodes return junk the DUT must ignore.
    always_comb begin
        case (alu_opcode)
            4'd1:    alu_result = ~(alu_input1 | alu_input2);
            4'd2:    alu_result = alu_input1 << alu_shift;
            4'd3:    alu_result = alu_input1 - alu_input2;
            4'd6:    alu_result = alu_input1 | alu_input2;
            4'd7:    alu_result = (alu_input1 > alu_input2) ? alu_input1 : alu_input2;
            4'd8:    alu_result = ~(alu_input1 & alu_input2);
            4'd9:    alu_result = 8'($signed(alu_input1) >>> alu_shift);
            4'd10:   alu_result = 8'(alu_input1 * alu_input2);
            default: alu_result = 8'h5A;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [4:0] sh, input logic [3:0] tag, input logic fwd);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_shift  = sh;
        cmd_tag    = tag;
        cmd_fwd    = fwd;
    endtask

    // Single command through an empty pipeline with rsp_ready held high.
    task automatic run_one(input string name, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [4:0] sh, input logic [3:0] tag,
                           input logic [7:0] exp_res, input logic [3:0] exp_czse);
        logic [15:0] cnt;
        drive_cmd(op, a, b, sh, tag, 1'b0);
        step();
        cmd_valid = 1'b0;
        check({name, "_lat1"}, 32'(rsp_valid), 32'd0);
        step();
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_result"}, 32'(rsp_result), 32'(exp_res));
        check({name, "_flags"}, 32'({rsp_carry, rsp_zero, rsp_sign, rsp_err}), 32'(exp_czse));
        check({name, "_tag"}, 32'(rsp_tag), 32'(tag));
        cnt = op_count;
        step();
        check({name, "_count"}, 32'(op_count), 32'(cnt + 16'd1));
        check({name, "_drained"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_shift  = '0;
        cmd_tag    = '0;
        cmd_fwd    = 1'b0;
        rsp_ready  = 1'b1;
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // flags packed as {carry, zero, sign, err}
        run_one("sub_borrow", 4'd3,  8'h05, 8'h07, 5'd0, 4'd3, 8'hFE, 4'b1010);
        run_one("sub_nob",    4'd3,  8'h07, 8'h05, 5'd0, 4'd2, 8'h02, 4'b0000);
        run_one("slt",        4'd0,  8'hFD, 8'h02, 5'd0, 4'd4, 8'h01, 4'b0000);
        run_one("sltu",       4'd4,  8'hFD, 8'h02, 5'd0, 4'd5, 8'h00, 4'b0100);
        run_one("seq",        4'd5,  8'h3C, 8'h3C, 5'd0, 4'd6, 8'h01, 4'b0000);
        run_one("sne",        4'd11, 8'h3C, 8'h3D, 5'd0, 4'd7, 8'h01, 4'b0000);
        run_one("or",         4'd6,  8'h0F, 8'hF0, 5'd0, 4'd8, 8'hFF, 4'b0010);
        run_one("sll",        4'd2,  8'h03, 8'h00, 5'd2, 4'd1, 8'h0C, 4'b0000);
        run_one("sra",        4'd9,  8'h80, 8'h00, 5'd1, 4'd10, 8'hC0, 4'b0010);
        run_one("illegal13",  4'd13, 8'h12, 8'h34, 5'd0, 4'd9, 8'h00, 4'b0101);

        // Backpressure: two commands held, third refused, then in-order drain.
        rsp_ready = 1'b0;
        drive_cmd(4'd6, 8'h01, 8'h02, 5'd0, 4'd0, 1'b0);
        exp_q.push_back(4'd0);
        step();
        drive_cmd(4'd6, 8'h03, 8'h04, 5'd0, 4'd1, 1'b0);
        exp_q.push_back(4'd1);
        step();
        drive_cmd(4'd6, 8'h05, 8'h06, 5'd0, 4'd2, 1'b0);
        exp_q.push_back(4'd2);
        #1;
        check("bp_ready_low", 32'(cmd_ready), 32'd0);
        step();
        check("bp_ready_hold", 32'(cmd_ready), 32'd0);
        check("bp_rsp_stable", 32'(rsp_result), 32'h03);
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_rise", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            logic [3:0] exp_tag;
            exp_tag = exp_q.pop_front();
            check("bp_drain_valid", 32'(rsp_valid), 32'd1);
            check("bp_drain_tag", 32'(rsp_tag), 32'(exp_tag));
            step();
            cmd_valid = 1'b0;
        end
        check("bp_empty", 32'(rsp_valid), 32'd0);
        check("bp_count", 32'(op_count), 32'd13);

        // Reset with two commands in flight.
        rsp_ready = 1'b0;
        drive_cmd(4'd3, 8'h44, 8'h11, 5'd3, 4'd5, 1'b0);
        step();
        drive_cmd(4'd3, 8'h55, 8'h22, 5'd3, 4'd6, 1'b0);
        step();
        cmd_valid = 1'b0;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_rsp_result", 32'(rsp_result), 32'd0);
        check("mrst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("mrst_op_count", 32'(op_count), 32'd0);
        check("mrst_alu", 32'({alu_opcode, alu_input1, alu_input2}), 32'd0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("mrst_count_after", 32'(op_count), 32'd0);

`ifdef ALU_ISSUE_FWD_EN
        // Dependent back-to-back commands: OR then SUB using the forwarded result.
        drive_cmd(4'd6, 8'h0F, 8'hF0, 5'd0, 4'd1, 1'b0);
        step();
        drive_cmd(4'd3, 8'h00, 8'h01, 5'd0, 4'd2, 1'b1);
        step();
        cmd_valid = 1'b0;
        check("fwd_r1_result", 32'(rsp_result), 32'hFF);
        check("fwd_r1_tag", 32'(rsp_tag), 32'd1);
        step();
        check("fwd_r2_valid", 32'(rsp_valid), 32'd1);
        check("fwd_r2_result", 32'(rsp_result), 32'hFE);
        check("fwd_r2_flags", 32'({rsp_carry, rsp_zero, rsp_sign, rsp_err}), 32'b0010);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
